// File: rtl/pcs_pkg.sv
// Shared constants and types for the 64b/66b transmit block encoder.
package pcs_pkg;

  // Terminate length field width: lengths 0..7 plus out-of-range detection.
  localparam int BLOCK_LEN_W = $clog2(9);

  // Sync headers.
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Block type bytes.
  localparam logic [7:0] BT_IDLE   = 8'h1E;
  localparam logic [7:0] BT_START0 = 8'h78;
  localparam logic [7:0] BT_START4 = 8'h33;
  localparam logic [7:0] BT_TERM0  = 8'h87;
  localparam logic [7:0] BT_TERM1  = 8'h99;
  localparam logic [7:0] BT_TERM2  = 8'hAA;
  localparam logic [7:0] BT_TERM3  = 8'hB4;
  localparam logic [7:0] BT_TERM4  = 8'hCC;
  localparam logic [7:0] BT_TERM5  = 8'hD2;
  localparam logic [7:0] BT_TERM6  = 8'hE1;
  localparam logic [7:0] BT_TERM7  = 8'hFF;

  // 7-bit control codes.
  localparam logic [6:0] CC_IDLE = 7'h00;
  localparam logic [6:0] CC_ERR  = 7'h1E;

  typedef enum logic {IDLE_ST = 1'b0, FRAME_ST = 1'b1} state_e;

  // What the index-0 flags of a block ask for, before protocol checking.
  typedef enum logic [2:0] {K_DATA, K_IDLE, K_START0, K_START4, K_TERM, K_BAD} kind_e;

  typedef struct packed {
    logic                   ctrl;
    logic                   start0;
    logic                   start4;
    logic                   idle;
    logic                   term;
    logic [BLOCK_LEN_W-1:0] len;
  } flags_t;

  // Decode block flags; ambiguous or out-of-range control requests become K_BAD.
  function automatic kind_e classify(input flags_t f);
    logic [2:0] n;
    n = 3'(f.start0) + 3'(f.start4) + 3'(f.idle) + 3'(f.term);
    if (!f.ctrl)                    return K_DATA;
    if (n != 3'd1)                  return K_BAD;
    if (f.start0)                   return K_START0;
    if (f.start4)                   return K_START4;
    if (f.idle)                     return K_IDLE;
    if (f.len > BLOCK_LEN_W'(7))    return K_BAD;
    return K_TERM;
  endfunction

endpackage

// File: rtl/pcs_term_type_lut.sv
// Terminate length to block type byte, plus mask of payload bytes 1..7 carrying data.
module pcs_term_type_lut
  import pcs_pkg::*;
(
  input  logic [BLOCK_LEN_W-1:0] term_len,
  output logic [7:0]             blk_type,
  output logic [6:0]             byte_mask
);

  // byte_mask[b] set means payload byte b+1 takes input byte b.
  always_comb begin
    blk_type  = BT_TERM0;
    byte_mask = 7'h00;
    case (term_len)
      BLOCK_LEN_W'(0): begin blk_type = BT_TERM0; byte_mask = 7'h00; end
      BLOCK_LEN_W'(1): begin blk_type = BT_TERM1; byte_mask = 7'h01; end
      BLOCK_LEN_W'(2): begin blk_type = BT_TERM2; byte_mask = 7'h03; end
      BLOCK_LEN_W'(3): begin blk_type = BT_TERM3; byte_mask = 7'h07; end
      BLOCK_LEN_W'(4): begin blk_type = BT_TERM4; byte_mask = 7'h0F; end
      BLOCK_LEN_W'(5): begin blk_type = BT_TERM5; byte_mask = 7'h1F; end
      BLOCK_LEN_W'(6): begin blk_type = BT_TERM6; byte_mask = 7'h3F; end
      BLOCK_LEN_W'(7): begin blk_type = BT_TERM7; byte_mask = 7'h7F; end
      default:         begin blk_type = BT_TERM0; byte_mask = 7'h00; end
    endcase
  end

endmodule

// File: rtl/pcs_tx_blk_enc.sv
// 64b/66b block encoder: packs phy words into blocks, checks frame protocol,
// and holds each block until the downstream scrambler takes it.
module pcs_tx_blk_enc
  import pcs_pkg::*;
#(
  parameter  int DATA_W      = 16,
  localparam int BLOCK_W     = 64,
  localparam int WORD_N      = BLOCK_W / DATA_W,
  localparam int LANE0_CNT_N = (DATA_W == 64) ? 2 : 1
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   ctrl_v_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic [LANE0_CNT_N-1:0] start_i,
  input  logic                   idle_i,
  input  logic                   term_i,
  input  logic [BLOCK_LEN_W-1:0] term_len_i,
  output logic                   ready_o,
  input  logic                   pcs_ready_i,
  output logic                   block_v_o,
  output logic [1:0]             block_head_o,
  output logic [BLOCK_W-1:0]     block_data_o,
  output logic                   err_o
);

  localparam int IDX_W = (WORD_N > 1) ? $clog2(WORD_N) : 1;

  logic               nreset_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BLOCK_W-1:0] buf_q;
  logic [BLOCK_W-1:0] raw;
  logic [1:0]         start_w;
  flags_t             flags_in, flags_q, flags_eff;
  kind_e              kind;
  state_e             state_q, state_d;
  logic               accept, complete, blk_err;
  logic [7:0]         term_type;
  logic [6:0]         term_mask;
  logic [1:0]         head_d;
  logic [BLOCK_W-1:0] data_d;

  // Words are taken whenever the output register can absorb a completed block.
  assign ready_o  = nreset_q & ~(block_v_o & ~pcs_ready_i);
  assign accept   = ready_o;
  assign complete = accept & (idx_q == IDX_W'(WORD_N - 1));

  // Gather port flags; flags only count on the first word of a block.
  always_comb begin
    start_w                    = '0;
    start_w[LANE0_CNT_N-1:0]   = start_i;
    flags_in.ctrl              = ctrl_v_i;
    flags_in.start0            = start_w[0];
    flags_in.start4            = start_w[1];
    flags_in.idle              = idle_i;
    flags_in.term              = term_i;
    flags_in.len               = term_len_i;
    flags_eff                  = (idx_q == '0) ? flags_in : flags_q;
  end

  assign kind = classify(flags_eff);

  // Full block image: captured words with the current word dropped into its slot.
  always_comb begin
    raw = buf_q;
    raw[int'(idx_q)*DATA_W +: DATA_W] = data_i;
  end

  pcs_term_type_lut u_term_lut (
    .term_len  (flags_eff.len),
    .blk_type  (term_type),
    .byte_mask (term_mask)
  );

  // Frame protocol: decide next state and whether this block becomes an error block.
  always_comb begin
    state_d = state_q;
    blk_err = 1'b0;
    case (state_q)
      IDLE_ST: begin
        case (kind)
          K_START0, K_START4: state_d = FRAME_ST;
          K_IDLE:             state_d = IDLE_ST;
          default:            blk_err = 1'b1;
        endcase
      end
      FRAME_ST: begin
        case (kind)
          K_DATA:  state_d = FRAME_ST;
          K_TERM:  state_d = IDLE_ST;
          K_IDLE:  begin blk_err = 1'b1; state_d = IDLE_ST; end
          default: blk_err = 1'b1;
        endcase
      end
      default: state_d = IDLE_ST;
    endcase
  end

  // Block formation: sync header plus payload for the selected block type.
  always_comb begin
    head_d = SYNC_CTRL;
    data_d = '0;
    if (blk_err) begin
      data_d[7:0] = BT_IDLE;
      for (int k = 0; k < 8; k++) data_d[8 + 7*k +: 7] = CC_ERR;
    end else begin
      case (kind)
        K_DATA: begin
          head_d = SYNC_DATA;
          data_d = raw;
        end
        K_IDLE:   data_d = {{8{CC_IDLE}}, BT_IDLE};
        K_START0: data_d = {raw[63:8], BT_START0};
        // C0..C3 and the O field stay zero.
        K_START4: data_d = {raw[63:40], 32'h0, BT_START4};
        K_TERM: begin
          data_d[7:0] = term_type;
          for (int b = 0; b < 7; b++)
            if (term_mask[b]) data_d[8*(b+1) +: 8] = raw[8*b +: 8];
        end
        default: data_d = '0;
      endcase
    end
  end

  // Ready is held low for the first cycle out of reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) nreset_q <= 1'b0;
    else         nreset_q <= 1'b1;
  end

  // Word index, partial-block buffer and first-word flag capture.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idx_q   <= '0;
      buf_q   <= '0;
      flags_q <= '0;
    end else if (accept) begin
      buf_q <= raw;
      if (idx_q == '0) flags_q <= flags_in;
      idx_q <= complete ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Protocol state advances once per completed block.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)       state_q <= IDLE_ST;
    else if (complete) state_q <= state_d;
  end

  // Output register: load on completion, otherwise drop valid once taken.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      block_v_o    <= 1'b0;
      block_head_o <= '0;
      block_data_o <= '0;
      err_o        <= 1'b0;
    end else begin
      err_o <= complete & blk_err;
      if (complete) begin
        block_v_o    <= 1'b1;
        block_head_o <= head_d;
        block_data_o <= data_d;
      end else if (pcs_ready_i) begin
        block_v_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcs_tx_blk_enc.sv
// Randomized self-checking bench for pcs_tx_blk_enc with a block-level reference model.
module tb_pcs_tx_blk_enc;

  localparam int DATA_W = 16;
  localparam int WORD_N = 64 / DATA_W;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        ctrl_v_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [0:0]  start_i = '0;
  logic        idle_i = 1'b0;
  logic        term_i = 1'b0;
  logic [3:0]  term_len_i = '0;
  logic        ready_o;
  logic        pcs_ready_i = 1'b0;
  logic        block_v_o;
  logic [1:0]  block_head_o;
  logic [63:0] block_data_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  bit m_frame = 0;

  typedef struct {bit ctrl; bit start; bit idle; bit term; int len; logic [63:0] data;} tblk_t;
  typedef struct {bit ctrl; bit start; bit idle; bit term; logic [3:0] len; logic [15:0] d;} word_t;
  typedef struct {logic [1:0] h; logic [63:0] d; bit e;} exp_t;

  logic [7:0] term_tab [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  pcs_tx_blk_enc #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .ctrl_v_i     (ctrl_v_i),
    .data_i       (data_i),
    .start_i      (start_i),
    .idle_i       (idle_i),
    .term_i       (term_i),
    .term_len_i   (term_len_i),
    .ready_o      (ready_o),
    .pcs_ready_i  (pcs_ready_i),
    .block_v_o    (block_v_o),
    .block_head_o (block_head_o),
    .block_data_o (block_data_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  function automatic tblk_t mk(bit c, bit s, bit i, bit t, int len, logic [63:0] d);
    tblk_t b;
    b.ctrl = c; b.start = s; b.idle = i; b.term = t; b.len = len; b.data = d;
    return b;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: expected block for one input block, tracking whether a frame is open.
  function automatic exp_t model(input tblk_t b);
    exp_t r;
    logic [7:0] ib [8];
    logic [7:0] ob [8];
    int nf;
    bit bad;
    for (int i = 0; i < 8; i++) begin ib[i] = b.data[8*i +: 8]; ob[i] = 8'h00; end
    r.e = 0; r.h = 2'b10; r.d = 64'h0;
    nf = int'(b.start) + int'(b.idle) + int'(b.term);
    bad = (nf != 1) || (b.term && b.len > 7);
    if (!b.ctrl) begin
      if (m_frame) begin r.h = 2'b01; for (int i = 0; i < 8; i++) ob[i] = ib[i]; end
      else r.e = 1;
    end else if (bad) begin
      r.e = 1;
    end else if (b.start) begin
      if (m_frame) r.e = 1;
      else begin m_frame = 1; ob[0] = 8'h78; for (int i = 1; i < 8; i++) ob[i] = ib[i]; end
    end else if (b.idle) begin
      if (m_frame) begin r.e = 1; m_frame = 0; end
      else ob[0] = 8'h1E;
    end else begin
      if (!m_frame) r.e = 1;
      else begin
        m_frame = 0;
        ob[0] = term_tab[b.len];
        for (int i = 0; i < b.len; i++) ob[i+1] = ib[i];
      end
    end
    for (int i = 0; i < 8; i++) r.d[8*i +: 8] = ob[i];
    if (r.e) begin
      r.h = 2'b10;
      r.d = 64'h0;
      r.d[7:0] = 8'h1E;
      for (int k = 0; k < 8; k++) r.d[8 + 7*k +: 7] = 7'h1E;
    end
    return r;
  endfunction

  task automatic drive(input word_t w);
    ctrl_v_i = w.ctrl; start_i = w.start; idle_i = w.idle;
    term_i = w.term; term_len_i = w.len; data_i = w.d;
  endtask

  function automatic word_t word_of(input tblk_t b, input int k);
    word_t w;
    w.d = b.data[16*k +: 16];
    if (k == 0) begin
      w.ctrl = b.ctrl; w.start = b.start; w.idle = b.idle; w.term = b.term; w.len = 4'(b.len);
    end else begin
      // Flags on non-first words must be ignored; make them noisy.
      w.ctrl = 1'($urandom); w.start = 1'($urandom); w.idle = 1'($urandom);
      w.term = 1'($urandom); w.len = 4'($urandom);
    end
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    ctrl_v_i = 1'($urandom); data_i = 16'($urandom); pcs_ready_i = 1'b1;
    #1;
    checks++;
    if ({block_v_o, block_head_o, block_data_o, err_o, ready_o} !== 69'h0) begin
      errors++;
      $display("FAIL reset_outputs v=%b h=%b d=%h e=%b rdy=%b expected all zero",
               block_v_o, block_head_o, block_data_o, err_o, ready_o);
    end
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    m_frame = 0;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_reset ready=%b expected 0", ready_o);
    end
  endtask

  // Feed blocks word by word with random back-pressure and check every delivered block.
  task automatic run_blocks(input tblk_t bl[$], input int bp_pct);
    word_t wq[$];
    exp_t  eq[$];
    exp_t  e;
    word_t fill;
    int    cyc = 0;
    bit    held = 0;
    bit    exp_err;
    logic [1:0]  ph = '0;
    logic [63:0] pd = '0;
    foreach (bl[i]) begin
      for (int k = 0; k < WORD_N; k++) wq.push_back(word_of(bl[i], k));
      eq.push_back(model(bl[i]));
    end
    while ((wq.size() > 0 || eq.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (wq.size() > 0) begin
        drive(wq[0]);
        pcs_ready_i = ($urandom_range(0, 99) >= bp_pct);
      end else begin
        fill = '{0, 0, 0, 0, 4'h0, 16'($urandom)};
        drive(fill);
        pcs_ready_i = 1'b1;
      end
      #1;
      if (held) begin
        checks++;
        if (block_v_o !== 1'b1 || block_head_o !== ph || block_data_o !== pd) begin
          errors++;
          $display("FAIL hold v=%b h=%b d=%h expected v=1 h=%b d=%h",
                   block_v_o, block_head_o, block_data_o, ph, pd);
        end
      end
      checks++;
      if (ready_o !== !(block_v_o && !pcs_ready_i)) begin
        errors++;
        $display("FAIL ready ready=%b v=%b pcs_ready=%b", ready_o, block_v_o, pcs_ready_i);
      end
      exp_err = (block_v_o && !held && eq.size() > 0) ? eq[0].e : 1'b0;
      checks++;
      if (err_o !== exp_err) begin
        errors++;
        $display("FAIL err_pulse err=%b expected %b", err_o, exp_err);
      end
      if (block_v_o && pcs_ready_i) begin
        checks++;
        if (eq.size() == 0) begin
          errors++;
          $display("FAIL extra_block h=%b d=%h expected none", block_head_o, block_data_o);
        end else begin
          e = eq.pop_front();
          if (block_head_o !== e.h || block_data_o !== e.d) begin
            errors++;
            $display("FAIL block h=%b d=%h expected h=%b d=%h",
                     block_head_o, block_data_o, e.h, e.d);
          end
        end
      end
      held = block_v_o && !pcs_ready_i;
      ph = block_head_o;
      pd = block_data_o;
      if (ready_o && wq.size() > 0) void'(wq.pop_front());
    end
    if (cyc >= 20000) begin
      checks++; errors++;
      $display("FAIL timeout words_left=%0d blocks_left=%0d", wq.size(), eq.size());
    end
  endtask

  // Present one word and wait (bounded) until it is going to be consumed.
  task automatic feed_word(input word_t w, input bit pr);
    bit ok = 0;
    @(negedge clk);
    drive(w);
    pcs_ready_i = pr;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (ready_o) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL feed_timeout ready=%b expected 1", ready_o);
    end
  endtask

  function automatic void add_frame(ref tblk_t q[$]);
    int nd = $urandom_range(0, 3);
    q.push_back(mk(1, 1, 0, 0, 0, rnd64()));
    for (int i = 0; i < nd; i++) q.push_back(mk(0, 0, 0, 0, 0, rnd64()));
    q.push_back(mk(1, 0, 0, 1, $urandom_range(0, 7), rnd64()));
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) q.push_back(mk(1, 0, 1, 0, 0, rnd64()));
  endfunction

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_idle();
    tblk_t q[$];
    do_reset();
    for (int i = 0; i < 3; i++) q.push_back(mk(1, 0, 1, 0, 0, rnd64()));
    run_blocks(q, 0);
  endtask

  task automatic test_start_term();
    tblk_t q[$];
    do_reset();
    q.push_back(mk(1, 1, 0, 0, 0, 64'hD555_5555_5555_553C));
    q.push_back(mk(0, 0, 0, 0, 0, rnd64()));
    q.push_back(mk(1, 0, 0, 1, 3, 64'hDEAD_BEEF_CCA3_A2A1));
    q.push_back(mk(1, 0, 1, 0, 0, rnd64()));
    run_blocks(q, 0);
  endtask

  task automatic test_protocol_err();
    tblk_t q[$];
    do_reset();
    q.push_back(mk(1, 0, 0, 1, 2, rnd64()));   // term outside a frame
    q.push_back(mk(0, 0, 0, 0, 0, rnd64()));   // data outside a frame
    q.push_back(mk(1, 1, 0, 0, 0, rnd64()));
    q.push_back(mk(1, 0, 1, 0, 0, rnd64()));   // idle inside a frame
    q.push_back(mk(1, 0, 1, 0, 0, rnd64()));   // now a clean idle
    q.push_back(mk(1, 1, 0, 0, 0, rnd64()));
    q.push_back(mk(1, 1, 0, 0, 0, rnd64()));   // start inside a frame
    q.push_back(mk(0, 0, 0, 0, 0, rnd64()));
    q.push_back(mk(1, 0, 0, 1, 9, rnd64()));   // length out of range
    q.push_back(mk(1, 1, 1, 0, 0, rnd64()));   // two flags at once
    q.push_back(mk(1, 0, 0, 1, 7, rnd64()));
    q.push_back(mk(1, 0, 0, 1, 0, rnd64()));   // term after frame closed
    run_blocks(q, 0);
  endtask

  task automatic test_random_frames();
    tblk_t q[$];
    do_reset();
    for (int f = 0; f < 15; f++) add_frame(q);
    run_blocks(q, 25);
  endtask

  task automatic test_back_to_back();
    tblk_t q[$];
    do_reset();
    for (int f = 0; f < 12; f++) add_frame(q);
    run_blocks(q, 65);
  endtask

  task automatic test_reset_mid_block();
    tblk_t q[$];
    tblk_t s;
    s = mk(1, 1, 0, 0, 0, rnd64());
    do_reset();
    for (int k = 0; k < WORD_N; k++) feed_word(word_of(mk(1, 0, 1, 0, 0, rnd64()), k), 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (block_v_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_stall v=%b ready=%b expected v=1 ready=0", block_v_o, ready_o);
    end
    feed_word(word_of(s, 0), 1'b1);
    feed_word(word_of(s, 1), 1'b1);
    @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if ({block_v_o, block_head_o, block_data_o, err_o, ready_o} !== 69'h0) begin
      errors++;
      $display("FAIL mid_reset v=%b h=%b d=%h e=%b rdy=%b expected all zero",
               block_v_o, block_head_o, block_data_o, err_o, ready_o);
    end
    @(negedge clk);
    nreset = 1'b1;
    m_frame = 0;
    q.push_back(mk(1, 1, 0, 0, 0, rnd64()));
    q.push_back(mk(1, 0, 0, 1, 5, rnd64()));
    run_blocks(q, 0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_start_term();
    test_protocol_err();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
